// File: rtl/iob_fifo_reader_pkg.sv
// Shared types for the FIFO-to-stream reader: FSM encoding and skid buffer depth.
package iob_fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 3;

endpackage

// File: rtl/iob_fifo_reader_buf.sv
// 3-entry shifting register queue; head is always entry 0.
module iob_fifo_reader_buf
  import iob_fifo_reader_pkg::*;
#(
  parameter int DATA_W = 21
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push,
  input  logic [DATA_W-1:0] data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic              do_pop;
  logic [1:0]        widx;

  assign do_pop = pop && (occ != 2'd0);
  // A simultaneous pop shifts the queue down, so the new word lands one slot lower.
  assign widx   = do_pop ? occ - 2'd1 : occ;
  assign head   = mem[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_pop)
        for (int i = 0; i < BUF_DEPTH - 1; i++) mem[i] <= mem[i+1];
      if (push) mem[widx] <= data;
      occ <= occ + 2'(push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/iob_fifo_reader.sv
// Drains a FIFO read port into a valid/ready stream of len words, tagging the last
// word and pulsing done afterwards. Reads are issued from registered state only.
module iob_fifo_reader
  import iob_fifo_reader_pkg::*;
#(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 3,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fifo_r_en_o,
  input  logic [DATA_W-1:0] fifo_r_data_i,
  input  logic              fifo_r_empty_i,
  input  logic [ADDR_W:0]   fifo_r_level_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  input  logic              m_ready_i
);

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  rd_rem, out_rem;
  logic              infl;
  logic              pop;
  logic [1:0]        occ;
  logic              unused_level;

  // Level is informational only; reads are gated by empty and buffer room.
  assign unused_level = ^fifo_r_level_i;

  // Words in the buffer plus the one in flight must fit in the 3 entries.
  assign fifo_r_en_o = (state == RUN) && (rd_rem != '0) && !fifo_r_empty_i &&
                       (({1'b0, occ} + {2'b0, infl}) < 3'd3);

  assign m_valid_o = (occ != 2'd0);
  assign m_last_o  = m_valid_o && (out_rem == LEN_W'(1));
  assign pop       = m_valid_o && m_ready_i;
  assign busy_o    = (state == RUN);
  assign done_o    = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = (len_i == '0) ? DONE : RUN;
      RUN:     if (pop && m_last_o) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      rd_rem  <= '0;
      out_rem <= '0;
      infl    <= 1'b0;
    end else begin
      state <= state_nxt;
      infl  <= fifo_r_en_o;
      if (state == IDLE && start_i && len_i != '0) begin
        rd_rem  <= len_i;
        out_rem <= len_i;
      end else begin
        if (fifo_r_en_o) rd_rem  <= rd_rem - LEN_W'(1);
        if (pop)         out_rem <= out_rem - LEN_W'(1);
      end
    end
  end

  iob_fifo_reader_buf #(.DATA_W(DATA_W)) u_buf (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (infl),
    .data  (fifo_r_data_i),
    .pop   (pop),
    .head  (m_data_o),
    .occ   (occ)
  );

endmodule

// File: tb/tb_iob_fifo_reader.sv
// Bench for iob_fifo_reader: behavioural FIFO, transfer-level model checked every cycle,
// and directed scenarios with literal expectations.
module tb_iob_fifo_reader;
  localparam int DATA_W = 21;
  localparam int ADDR_W = 3;
  localparam int LEN_W  = 16;
  localparam int LVW    = ADDR_W + 1;
  localparam int FDEPTH = 8;

  logic              clk = 1'b0;
  logic              rst, start, m_ready;
  logic [LEN_W-1:0]  len;
  logic              busy, done, r_en, m_valid, m_last;
  logic [DATA_W-1:0] r_data = '0;
  logic [DATA_W-1:0] m_data;
  logic              empty = 1'b1;
  logic [ADDR_W:0]   level = '0;
  logic              wr_en, fifo_clr;
  logic [DATA_W-1:0] wr_data;

  always #5 clk = ~clk;

  iob_fifo_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len),
    .busy_o(busy), .done_o(done), .fifo_r_en_o(r_en),
    .fifo_r_data_i(r_data), .fifo_r_empty_i(empty), .fifo_r_level_i(level),
    .m_valid_o(m_valid), .m_data_o(m_data), .m_last_o(m_last), .m_ready_i(m_ready)
  );

  // Behavioural FIFO with 1-cycle read latency; rd_hist records every word read out.
  logic [DATA_W-1:0] fq[$];
  logic [DATA_W-1:0] rd_hist[$];
  always @(posedge clk) begin
    if (fifo_clr) fq.delete();
    else begin
      if (r_en && fq.size() != 0) begin
        r_data <= fq[0];
        rd_hist.push_back(fq[0]);
        void'(fq.pop_front());
      end
      if (wr_en && fq.size() < FDEPTH) fq.push_back(wr_data);
    end
    empty <= (fq.size() == 0);
    level <= LVW'(fq.size());
  end

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transfer-level model: phase, words owed, reads issued, beats delivered.
  typedef enum {P_IDLE, P_RUN, P_DONE} phase_t;
  phase_t ph = P_IDLE;
  int x_len = 0, x_reads = 0, x_beats = 0, rd_ptr = 0;
  int reads_total = 0, beats_total = 0, done_total = 0;
  logic [DATA_W-1:0] beat_log[$];
  logic stall_q = 1'b0, stall_last = 1'b0, rst_q = 1'b0;
  logic [DATA_W-1:0] stall_data = '0;
  bit mon_en = 1'b0;

  always @(negedge clk) if (mon_en) begin
    if (rst_q) begin
      chk("post_rst_valid", m_valid, 0);
      chk("post_rst_last", m_last, 0);
      chk("post_rst_data", m_data, 0);
      chk("post_rst_ren", r_en, 0);
      rd_ptr = rd_hist.size();
    end
    chk("busy", busy, ph == P_RUN);
    chk("done", done, ph == P_DONE);
    if (r_en) begin
      chk("read_nonempty", empty, 0);
      chk("read_no_overread", x_reads < x_len, 1);
      chk("outstanding_le3", (x_reads - x_beats) < 3, 1);
      x_reads++; reads_total++;
    end
    if (stall_q) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, stall_data);
      chk("stall_last", m_last, stall_last);
    end
    if (m_valid) chk("last_flag", m_last, x_beats == x_len - 1);
    if (m_valid && m_ready) begin
      if (rd_ptr < rd_hist.size()) chk("beat_data", m_data, rd_hist[rd_ptr]);
      else chk("beat_without_read", 0, 1);
      beat_log.push_back(m_data);
      rd_ptr++; x_beats++; beats_total++;
    end
    if (done) done_total++;
    stall_q = m_valid && !m_ready; stall_data = m_data; stall_last = m_last;
    rst_q = rst;
    if (rst) begin
      ph = P_IDLE; x_len = 0; x_reads = 0; x_beats = 0; stall_q = 1'b0;
    end else begin
      case (ph)
        P_IDLE: if (start) begin
          x_len = int'(len); x_reads = 0; x_beats = 0;
          ph = (len == '0) ? P_DONE : P_RUN;
        end
        P_RUN:  if (m_valid && m_ready && x_beats == x_len) ph = P_DONE;
        P_DONE: ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_words(input logic [DATA_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_data = DATA_W'(base + DATA_W'(i)); tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic start_xfer(input int n);
    start = 1'b1; len = LEN_W'(n); tick(); start = 1'b0;
  endtask

  int run = 0, maxrun = 0;
  task automatic run_to_done(input int d0, input int budget, input string tag);
    int n = 0;
    run = 0; maxrun = 0;
    while (done_total == d0 && n < budget) begin
      if (r_en) begin run++; if (run > maxrun) maxrun = run; end else run = 0;
      tick(); n++;
    end
    if (done_total == d0) chk({tag, "_timeout"}, 0, 1);
  endtask

  int r0, b0, d0, n;
  initial begin
    rst = 1'b1; start = 1'b0; len = '0; m_ready = 1'b1;
    wr_en = 1'b0; wr_data = '0; fifo_clr = 1'b0;
    repeat (3) tick();
    chk("reset_busy", busy, 0);  chk("reset_done", done, 0);
    chk("reset_ren", r_en, 0);   chk("reset_valid", m_valid, 0);
    chk("reset_last", m_last, 0); chk("reset_data", m_data, 0);
    rst = 1'b0; mon_en = 1'b1; tick();

    // 1: preloaded A0..A3, full throughput
    push_words(21'h0A0, 4); tick();
    r0 = reads_total; b0 = beats_total; d0 = done_total;
    start_xfer(4);
    run_to_done(d0, 30, "t1");
    chk("t1_reads", reads_total - r0, 4);
    chk("t1_ren_run", maxrun, 4);
    chk("t1_beats", beats_total - b0, 4);
    for (int i = 0; i < 4; i++) chk("t1_beat", beat_log[b0+i], 21'h0A0 + i);
    chk("t1_done_cnt", done_total - d0, 1);
    tick();
    chk("t1_busy_after", busy, 0);
    chk("t1_level", level, 0);

    // 2: FIFO trickles one word every 5 cycles
    r0 = reads_total; b0 = beats_total; d0 = done_total;
    start_xfer(3);
    for (int k = 0; k < 3; k++) begin
      repeat (4) tick();
      push_words(DATA_W'(21'h0B0 + k), 1);
    end
    run_to_done(d0, 40, "t2");
    chk("t2_reads", reads_total - r0, 3);
    for (int i = 0; i < 3; i++) chk("t2_beat", beat_log[b0+i], 21'h0B0 + i);
    tick();
    chk("t2_level", level, 0);

    // 3: 8 words, consumer stalled for 10 cycles
    push_words(21'h0C0, 8); tick();
    r0 = reads_total; b0 = beats_total; d0 = done_total;
    m_ready = 1'b0;
    start_xfer(8);
    repeat (9) tick();
    chk("t3_stall_reads", reads_total - r0, 3);
    chk("t3_stall_beats", beats_total - b0, 0);
    m_ready = 1'b1;
    run_to_done(d0, 40, "t3");
    chk("t3_reads", reads_total - r0, 8);
    chk("t3_beats", beats_total - b0, 8);
    for (int i = 0; i < 8; i++) chk("t3_beat", beat_log[b0+i], 21'h0C0 + i);
    tick();
    chk("t3_level", level, 0);

    // 4: zero-length transfer
    r0 = reads_total; b0 = beats_total; d0 = done_total;
    start_xfer(0);
    chk("t4_done_next", done, 1);
    chk("t4_busy", busy, 0);
    repeat (3) tick();
    chk("t4_reads", reads_total - r0, 0);
    chk("t4_done_cnt", done_total - d0, 1);

    // 5: reset one cycle after 2nd beat; D0..D4 already read, D5.. remain
    push_words(21'h0D0, 8); tick();
    b0 = beats_total;
    start_xfer(6);
    n = 0;
    while (beats_total < b0 + 2 && n < 20) begin tick(); n++; end
    if (beats_total < b0 + 2) chk("t5_timeout", 0, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_busy", busy, 0); chk("t5_done", done, 0); chk("t5_ren", r_en, 0);
    chk("t5_valid", m_valid, 0); chk("t5_last", m_last, 0); chk("t5_data", m_data, 0);
    chk("t5_level", level, 3);
    chk("t5_next_word", fq[0], 21'h0D5);
    r0 = reads_total; b0 = beats_total; d0 = done_total;
    start_xfer(2);
    run_to_done(d0, 30, "t5");
    chk("t5_reads", reads_total - r0, 2);
    for (int i = 0; i < 2; i++) chk("t5_beat", beat_log[b0+i], 21'h0D5 + i);
    fifo_clr = 1'b1; tick(); fifo_clr = 1'b0; tick();

    // 6: start re-pulsed during RUN is ignored
    push_words(21'h0E0, 6); tick();
    r0 = reads_total; b0 = beats_total; d0 = done_total;
    start_xfer(2);
    start = 1'b1; len = LEN_W'(5); tick(); start = 1'b0;
    run_to_done(d0, 30, "t6");
    repeat (6) tick();
    chk("t6_reads", reads_total - r0, 2);
    chk("t6_done_cnt", done_total - d0, 1);
    chk("t6_level", level, 4);
    chk("t6_busy", busy, 0);
    for (int i = 0; i < 2; i++) chk("t6_beat", beat_log[b0+i], 21'h0E0 + i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before finish");
    $fatal(1);
  end

endmodule
